// File: rtl/bpsk_symbol_mapper_pkg.sv
// bpsk_symbol_mapper_pkg
//   Shared definitions for the BPSK symbol mapper: the 2-bit signed symbol
//   codes fed to rrc_fir, the mapper FSM state type and the bit->symbol map.
package bpsk_symbol_mapper_pkg;

  localparam logic [1:0] SYM_POS  = 2'b01;  // +1
  localparam logic [1:0] SYM_NEG  = 2'b11;  // -1
  localparam logic [1:0] SYM_ZERO = 2'b00;  //  0

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Antipodal map: bit 0 -> +1, bit 1 -> -1
  function automatic logic [1:0] map_bit(input logic b);
    return b ? SYM_NEG : SYM_POS;
  endfunction

endpackage

// File: rtl/bpsk_symbol_mapper_if.sv
// bpsk_symbol_mapper_if
//   Serial bit stream handshake into the mapper.
//   bit_in    : data bit
//   bit_valid : bit_in valid (source -> mapper)
//   bit_ready : mapper can accept a bit (mapper -> source)
//   modport master = bit source, modport slave = mapper.
interface bpsk_symbol_mapper_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (output bit_in, output bit_valid, input bit_ready);
  modport slave  (input bit_in, input bit_valid, output bit_ready);
endinterface

// File: rtl/bpsk_symbol_mapper_bit_fifo.sv
// bit_fifo
//   1-bit wide FIFO, DEPTH entries (power of 2, >=2). No bypass: a bit pushed
//   in cycle N is visible on o_dout / o_count from cycle N+1. Simultaneous
//   push and pop keep the count unchanged. Push when full and pop when empty
//   are ignored.
//   Ports: clk, rst_n (async active-low), i_push, i_din, i_pop,
//          o_dout (head bit), o_full, o_empty, o_count.
module bit_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_din,
  input  logic                         i_pop,
  output logic                         o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bpsk_symbol_mapper.sv
// bpsk_symbol_mapper
//   Buffers a serial bit stream, maps bits to 2-bit signed antipodal symbols
//   and zero-stuffs to SPS samples per symbol on each sample_en tick. Each
//   burst ends with FLUSH_LEN zero samples to drain the downstream rrc_fir.
//   Optional build macro DIFF_ENC_EN: differential encoding d_k = b_k ^ d_(k-1)
//   before mapping, d cleared on reset and at every burst start.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     sample_en   : one-cycle sample-rate tick gating all symbol activity
//     bit_if      : bit stream handshake (slave), bit_ready = FIFO not full
//     sym_out     : registered symbol, 01=+1, 11=-1, 00=0
//     sym_valid   : one-cycle pulse, sym_out updated this cycle
//     busy        : FSM not idle
//     underrun    : sticky, FIFO ran dry at a symbol boundary while a bit
//                   was arriving; cleared only by reset
module bpsk_symbol_mapper
  import bpsk_symbol_mapper_pkg::*;
#(
  parameter int unsigned SPS         = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned START_LEVEL = 4,
  parameter int unsigned FLUSH_LEN   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_en,
  bpsk_symbol_mapper_if.slave        bit_if,
  output logic [1:0]                 sym_out,
  output logic                       sym_valid,
  output logic                       busy,
  output logic                       underrun
);

  localparam int unsigned PH_W = $clog2(SPS);
  localparam int unsigned FL_W = $clog2(FLUSH_LEN + 1);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [PH_W-1:0] r_phase;
  logic [PH_W-1:0] w_phase_nx;
  logic [PH_W-1:0] w_phase_inc;
  logic [FL_W-1:0] r_flush;
  logic [FL_W-1:0] w_flush_nx;
  logic [1:0]      r_sym_out;
  logic            r_sym_valid;
  logic            r_underrun;

  logic            w_pop;
  logic            w_active;
  logic [1:0]      w_sym;
  logic            w_underrun_set;
  logic            w_enter_run;
  logic            w_bit_enc;

  logic            w_fifo_dout;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;

  bit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bit_if.bit_valid),
    .i_din   (bit_if.bit_in),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bit_if.bit_ready = !w_fifo_full;
  assign busy             = (r_state != ST_IDLE);
  assign sym_out          = r_sym_out;
  assign sym_valid        = r_sym_valid;
  assign underrun         = r_underrun;
  assign w_enter_run      = (r_state == ST_IDLE) && (w_next_state == ST_RUN);
  assign w_phase_inc      = (r_phase == PH_W'(SPS - 1)) ? '0 : r_phase + PH_W'(1);

`ifdef DIFF_ENC_EN
  logic r_d;
  logic w_d_prev;

  // Burst start always pops, so forcing d_prev to 0 here is the same as
  // clearing r_d on IDLE->RUN entry.
  assign w_d_prev  = w_enter_run ? 1'b0 : r_d;
  assign w_bit_enc = w_fifo_dout ^ w_d_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_d <= 1'b0;
    else if (w_pop) r_d <= w_bit_enc;
  end
`else
  assign w_bit_enc = w_fifo_dout;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic, evaluated only on sample ticks
  always_comb begin
    w_next_state = r_state;
    if (sample_en) begin
      case (r_state)
        ST_IDLE:
          if (w_fifo_count >= CW'(START_LEVEL)) w_next_state = ST_RUN;
        ST_RUN:
          if ((r_phase == '0) && w_fifo_empty)
            w_next_state = (FLUSH_LEN <= 1) ? ST_IDLE : ST_FLUSH;
        ST_FLUSH:
          if (r_flush >= FL_W'(FLUSH_LEN - 1)) w_next_state = ST_IDLE;
        default:
          w_next_state = ST_IDLE;
      endcase
    end
  end

  // Output / datapath control. The entry tick from IDLE already acts as the
  // first RUN phase-0 sample (pop + emit), so RUN starts at phase 1.
  always_comb begin
    w_pop          = 1'b0;
    w_active       = 1'b0;
    w_sym          = SYM_ZERO;
    w_underrun_set = 1'b0;
    w_phase_nx     = r_phase;
    w_flush_nx     = r_flush;
    if (sample_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_enter_run) begin
            w_active   = 1'b1;
            w_pop      = 1'b1;
            w_sym      = map_bit(w_bit_enc);
            w_phase_nx = w_phase_inc;
            w_flush_nx = '0;
          end
        end
        ST_RUN: begin
          w_active = 1'b1;
          if ((r_phase == '0) && w_fifo_empty) begin
            // Empty boundary: this zero is flush sample 1
            w_underrun_set = bit_if.bit_valid;
            w_flush_nx     = FL_W'(1);
            w_phase_nx     = '0;
          end else begin
            if (r_phase == '0) begin
              w_pop = 1'b1;
              w_sym = map_bit(w_bit_enc);
            end
            w_phase_nx = w_phase_inc;
          end
        end
        ST_FLUSH: begin
          w_active   = 1'b1;
          w_flush_nx = (w_next_state == ST_IDLE) ? '0 : r_flush + FL_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= '0;
      r_flush     <= '0;
      r_sym_out   <= SYM_ZERO;
      r_sym_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_phase     <= w_phase_nx;
      r_flush     <= w_flush_nx;
      r_sym_valid <= w_active;
      if (w_active)       r_sym_out  <= w_sym;
      if (w_underrun_set) r_underrun <= 1'b1;
    end
  end

endmodule
